mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter_rr_picker.sv | 40 ++++
 rtl/mem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared package for the memory arbiter.
// Holds the 2-bit arbiter FSM state encoding used by the top-level arbiter.
package mem_arbiter_pkg;

    // Arbiter FSM states. The encoding is fixed at 2 bits so every state
    // vector in the design is the same width.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_READ_WAIT  = 2'd1,
        ST_WRITE_WAIT = 2'd2,
        ST_RELEASE    = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational rotating-priority search.
// Finds the first asserted request starting at ptr and searching upward,
// wrapping from NUM_REQ-1 back to 0.
//   req   : request vector, one bit per requester
//   ptr   : index where the search starts (highest priority)
//   found : at least one request is asserted
//   idx   : index of the selected requester (0 when found is low)
module rr_picker
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 8,
    parameter int IDX_BITS = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [IDX_BITS-1:0] ptr,
    output logic                found,
    output logic [IDX_BITS-1:0] idx
);

    int cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Wrap with a subtraction rather than a modulo; ptr is always
            // below NUM_REQ, so one subtraction is enough.
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = IDX_BITS'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory read channel and one memory write channel
// between NUM_CONSUMERS requesters using round-robin priority. One
// transaction is in flight at a time; every output is registered.
//
// Ports:
//   clk, reset                        single clock, synchronous active-high reset
//   consumer_read_valid/address       per-consumer read requests
//   consumer_read_ready/data          per-consumer read completion and data
//   consumer_write_valid/address/data per-consumer write requests
//   consumer_write_ready              per-consumer write completion
//   mem_read_*                        memory read channel (valid/address out,
//                                     ready/data in)
//   mem_write_*                       memory write channel (valid/address/data
//                                     out, ready in)
//   busy                              high whenever the FSM is not in IDLE
//   grant_id                          index of the current or last grant
//
// state         | meaning
// --------------+------------------------------------------------------------
// ST_IDLE       | no transaction; pick the next requester from rr_ptr
// ST_READ_WAIT  | mem_read_valid held until mem_read_ready
// ST_WRITE_WAIT | mem_write_valid held until mem_write_ready
// ST_RELEASE    | consumer ready held until the served valid drops
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,

    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,

    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,

    output logic                                   mem_read_valid,
    output logic [ADDR_BITS-1:0]                   mem_read_address,
    input  logic                                   mem_read_ready,
    input  logic [DATA_BITS-1:0]                   mem_read_data,

    output logic                                   mem_write_valid,
    output logic [ADDR_BITS-1:0]                   mem_write_address,
    output logic [DATA_BITS-1:0]                   mem_write_data,
    input  logic                                   mem_write_ready,

    output logic                                   busy,
    output logic [$clog2(NUM_CONSUMERS)-1:0]       grant_id
);

    localparam int IDX_BITS = $clog2(NUM_CONSUMERS);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_CONSUMERS - 1);

    arb_state_e state_q, state_d;
    logic [IDX_BITS-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_BITS-1:0] grant_id_q, grant_id_d;
    logic served_read_q, served_read_d;
    logic busy_q, busy_d;

    logic                 mem_read_valid_q, mem_read_valid_d;
    logic [ADDR_BITS-1:0] mem_read_address_q, mem_read_address_d;
    logic                 mem_write_valid_q, mem_write_valid_d;
    logic [ADDR_BITS-1:0] mem_write_address_q, mem_write_address_d;
    logic [DATA_BITS-1:0] mem_write_data_q, mem_write_data_d;

    logic [NUM_CONSUMERS-1:0]                consumer_read_ready_q, consumer_read_ready_d;
    logic [NUM_CONSUMERS-1:0]                consumer_write_ready_q, consumer_write_ready_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data_q, consumer_read_data_d;

    logic                pick_found;
    logic [IDX_BITS-1:0] pick_idx;
    logic                served_valid;

    rr_picker #(
        .NUM_REQ  (NUM_CONSUMERS),
        .IDX_BITS (IDX_BITS)
    ) u_rr_picker (
        .req   (consumer_read_valid | consumer_write_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Valid of the request type that was actually served; RELEASE waits on
    // this one only, so a pending write from the same consumer does not
    // stall the release of its read.
    assign served_valid = served_read_q ? consumer_read_valid[grant_id_q]
                                        : consumer_write_valid[grant_id_q];

    always_comb begin
        state_d                = state_q;
        rr_ptr_d               = rr_ptr_q;
        grant_id_d             = grant_id_q;
        served_read_d          = served_read_q;
        mem_read_valid_d       = mem_read_valid_q;
        mem_read_address_d     = mem_read_address_q;
        mem_write_valid_d      = mem_write_valid_q;
        mem_write_address_d    = mem_write_address_q;
        mem_write_data_d       = mem_write_data_q;
        consumer_read_ready_d  = consumer_read_ready_q;
        consumer_write_ready_d = consumer_write_ready_q;
        consumer_read_data_d   = consumer_read_data_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_id_d = pick_idx;
                    // A consumer with both requests pending gets its read
                    // first; the write wins a later round.
                    if (consumer_read_valid[pick_idx]) begin
                        served_read_d      = 1'b1;
                        state_d            = ST_READ_WAIT;
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = consumer_read_address[pick_idx];
                    end else begin
                        served_read_d       = 1'b0;
                        state_d             = ST_WRITE_WAIT;
                        mem_write_valid_d   = 1'b1;
                        mem_write_address_d = consumer_write_address[pick_idx];
                        mem_write_data_d    = consumer_write_data[pick_idx];
                    end
                end
            end

            ST_READ_WAIT: begin
                if (mem_read_ready) begin
                    mem_read_valid_d                 = 1'b0;
                    consumer_read_data_d[grant_id_q] = mem_read_data;
                    consumer_read_ready_d[grant_id_q] = 1'b1;
                    state_d                          = ST_RELEASE;
                end
            end

            ST_WRITE_WAIT: begin
                if (mem_write_ready) begin
                    mem_write_valid_d                  = 1'b0;
                    consumer_write_ready_d[grant_id_q] = 1'b1;
                    state_d                            = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                if (!served_valid) begin
                    consumer_read_ready_d  = '0;
                    consumer_write_ready_d = '0;
                    rr_ptr_d = (grant_id_q == LAST_IDX) ? '0 : grant_id_q + 1'b1;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // busy is registered alongside the state so it tracks it exactly.
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q                <= ST_IDLE;
            rr_ptr_q               <= '0;
            grant_id_q             <= '0;
            served_read_q          <= 1'b0;
            busy_q                 <= 1'b0;
            mem_read_valid_q       <= 1'b0;
            mem_read_address_q     <= '0;
            mem_write_valid_q      <= 1'b0;
            mem_write_address_q    <= '0;
            mem_write_data_q       <= '0;
            consumer_read_ready_q  <= '0;
            consumer_write_ready_q <= '0;
            consumer_read_data_q   <= '0;
        end else begin
            state_q                <= state_d;
            rr_ptr_q               <= rr_ptr_d;
            grant_id_q             <= grant_id_d;
            served_read_q          <= served_read_d;
            busy_q                 <= busy_d;
            mem_read_valid_q       <= mem_read_valid_d;
            mem_read_address_q     <= mem_read_address_d;
            mem_write_valid_q      <= mem_write_valid_d;
            mem_write_address_q    <= mem_write_address_d;
            mem_write_data_q       <= mem_write_data_d;
            consumer_read_ready_q  <= consumer_read_ready_d;
            consumer_write_ready_q <= consumer_write_ready_d;
            consumer_read_data_q   <= consumer_read_data_d;
        end
    end

    assign consumer_read_ready  = consumer_read_ready_q;
    assign consumer_read_data   = consumer_read_data_q;
    assign consumer_write_ready = consumer_write_ready_q;
    assign mem_read_valid       = mem_read_valid_q;
    assign mem_read_address     = mem_read_address_q;
    assign mem_write_valid      = mem_write_valid_q;
    assign mem_write_address    = mem_write_address_q;
    assign mem_write_data       = mem_write_data_q;
    assign busy                 = busy_q;
    assign grant_id             = grant_id_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (8 consumers, 8-bit address/data).
module tb_mem_arbiter;

    logic clk;
    logic reset;

    logic [7:0]      consumer_read_valid;
    logic [7:0][7:0] consumer_read_address;
    logic [7:0]      consumer_read_ready;
    logic [7:0][7:0] consumer_read_data;
    logic [7:0]      consumer_write_valid;
    logic [7:0][7:0] consumer_write_address;
    logic [7:0][7:0] consumer_write_data;
    logic [7:0]      consumer_write_ready;

    logic       mem_read_valid;
    logic [7:0] mem_read_address;
    logic       mem_read_ready;
    logic [7:0] mem_read_data;
    logic       mem_write_valid;
    logic [7:0] mem_write_address;
    logic [7:0] mem_write_data;
    logic       mem_write_ready;

    logic       busy;
    logic [2:0] grant_id;

    int checks = 0;
    int errors = 0;
    int overlap_cnt = 0;
    int multi_ready_cnt = 0;
    int wr_activity_cnt = 0;
    bit watch_wr = 1'b0;

    mem_arbiter #(
        .ADDR_BITS     (8),
        .DATA_BITS     (8),
        .NUM_CONSUMERS (8)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (consumer_read_valid),
        .consumer_read_address  (consumer_read_address),
        .consumer_read_ready    (consumer_read_ready),
        .consumer_read_data     (consumer_read_data),
        .consumer_write_valid   (consumer_write_valid),
        .consumer_write_address (consumer_write_address),
        .consumer_write_data    (consumer_write_data),
        .consumer_write_ready   (consumer_write_ready),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (mem_read_ready),
        .mem_read_data          (mem_read_data),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (mem_write_ready),
        .busy                   (busy),
        .grant_id               (grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Invariant monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_read_valid && mem_write_valid) overlap_cnt++;
            if (!$onehot0({consumer_read_ready, consumer_write_ready})) multi_ready_cnt++;
            if (watch_wr && (mem_write_valid || consumer_write_ready != 8'h00)) wr_activity_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset                  = 1'b1;
        consumer_read_valid    = '0;
        consumer_read_address  = '0;
        consumer_write_valid   = '0;
        consumer_write_address = '0;
        consumer_write_data    = '0;
        mem_read_ready         = 1'b0;
        mem_read_data          = '0;
        mem_write_ready        = 1'b0;
        step(2);

        // Reset state
        check("rst_busy",      64'(busy), 64'(0));
        check("rst_grant",     64'(grant_id), 64'(0));
        check("rst_mrv",       64'(mem_read_valid), 64'(0));
        check("rst_mwv",       64'(mem_write_valid), 64'(0));
        check("rst_rdy",       64'({consumer_read_ready, consumer_write_ready}), 64'(0));
        check("rst_rdata",     64'(consumer_read_data), 64'(0));
        reset = 1'b0;

        // Single read from consumer 3
        watch_wr = 1'b1;
        consumer_read_valid[3]   = 1'b1;
        consumer_read_address[3] = 8'h2A;
        step(1);
        check("rd3_mrv",   64'(mem_read_valid), 64'(1));
        check("rd3_addr",  64'(mem_read_address), 64'(8'h2A));
        check("rd3_grant", 64'(grant_id), 64'(3));
        check("rd3_busy",  64'(busy), 64'(1));
        step(1);
        check("rd3_hold",  64'(mem_read_valid), 64'(1));
        check("rd3_rdy_early", 64'(consumer_read_ready), 64'(0));
        mem_read_ready = 1'b1;
        mem_read_data  = 8'h5C;
        step(1);
        check("rd3_mrv_drop", 64'(mem_read_valid), 64'(0));
        check("rd3_ready",    64'(consumer_read_ready), 64'(8'h08));
        check("rd3_data",     64'(consumer_read_data[3]), 64'(8'h5C));
        mem_read_ready = 1'b0;
        mem_read_data  = 8'h00;
        consumer_read_valid[3] = 1'b0;
        step(1);
        check("rd3_rdy_clr",  64'(consumer_read_ready), 64'(0));
        check("rd3_idle",     64'(busy), 64'(0));
        check("rd3_data_hold", 64'(consumer_read_data[3]), 64'(8'h5C));
        check("rd3_no_write", 64'(wr_activity_cnt), 64'(0));
        watch_wr = 1'b0;

        // Fairness: all consumers read continuously, starting from reset
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) consumer_read_address[i] = 8'(i * 17);
        consumer_read_valid = 8'hFF;
        step(1);
        for (int k = 0; k < 9; k++) begin
            int c;
            c = k % 8;
            check($sformatf("fair_grant%0d", k), 64'(grant_id), 64'(c));
            check($sformatf("fair_addr%0d", k), 64'(mem_read_address), 64'(c * 17));
            check($sformatf("fair_mrv%0d", k), 64'(mem_read_valid), 64'(1));
            mem_read_ready = 1'b1;
            mem_read_data  = 8'(8'hA0 + k);
            step(1);
            check($sformatf("fair_rdy%0d", k), 64'(consumer_read_ready), 64'(1) << c);
            check($sformatf("fair_data%0d", k), 64'(consumer_read_data[c]), 64'(8'hA0 + k));
            mem_read_ready = 1'b0;
            consumer_read_valid[c] = 1'b0;
            step(1);
            check($sformatf("fair_idle%0d", k), 64'(busy), 64'(0));
            consumer_read_valid[c] = 1'b1;
            step(1);
        end
        consumer_read_valid = '0;
        reset = 1'b1;
        step(1);
        reset = 1'b0;

        // Read and write together from consumer 1: read first, then write
        consumer_read_valid[1]    = 1'b1;
        consumer_read_address[1]  = 8'h33;
        consumer_write_valid[1]   = 1'b1;
        consumer_write_address[1] = 8'h10;
        consumer_write_data[1]    = 8'h77;
        step(1);
        check("rw_read_first", 64'({mem_read_valid, mem_write_valid}), 64'(2'b10));
        check("rw_rd_addr",    64'(mem_read_address), 64'(8'h33));
        mem_read_ready = 1'b1;
        mem_read_data  = 8'h99;
        step(1);
        check("rw_rd_ready",   64'({consumer_read_ready, consumer_write_ready}), 64'(16'h0200));
        mem_read_ready = 1'b0;
        consumer_read_valid[1] = 1'b0;
        step(1);
        check("rw_idle",       64'(busy), 64'(0));
        step(1);
        check("rw_write",      64'({mem_read_valid, mem_write_valid}), 64'(2'b01));
        check("rw_wr_addr",    64'(mem_write_address), 64'(8'h10));
        check("rw_wr_data",    64'(mem_write_data), 64'(8'h77));
        check("rw_wr_grant",   64'(grant_id), 64'(1));
        // Ready on the non-matching channel must be ignored.
        mem_read_ready = 1'b1;
        mem_read_data  = 8'hEE;
        step(1);
        check("rw_ignore_rrdy", 64'(mem_write_valid), 64'(1));
        check("rw_ignore_data", 64'(consumer_read_data[1]), 64'(8'h99));
        check("rw_ignore_rdy",  64'({consumer_read_ready, consumer_write_ready}), 64'(0));
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b1;
        step(1);
        check("rw_wr_done",    64'({mem_write_valid, consumer_write_ready}), 64'(9'h002));
        mem_write_ready = 1'b0;
        consumer_write_valid[1] = 1'b0;
        step(1);
        check("rw_wr_release", 64'({busy, consumer_write_ready}), 64'(0));

        // Abandon: consumer 5 drops read_valid during READ_WAIT
        consumer_read_valid[5]   = 1'b1;
        consumer_read_address[5] = 8'h44;
        step(1);
        check("ab_grant", 64'(grant_id), 64'(5));
        consumer_read_valid[5] = 1'b0;
        step(1);
        check("ab_no_abort", 64'(mem_read_valid), 64'(1));
        mem_read_ready = 1'b1;
        mem_read_data  = 8'h3C;
        step(1);
        check("ab_ready", 64'(consumer_read_ready), 64'(8'h20));
        mem_read_ready = 1'b0;
        step(1);
        check("ab_ready_1cyc", 64'(consumer_read_ready), 64'(0));
        check("ab_idle",       64'(busy), 64'(0));
        check("ab_data",       64'(consumer_read_data[5]), 64'(8'h3C));

        // Reset in WRITE_WAIT
        consumer_write_valid[2]   = 1'b1;
        consumer_write_address[2] = 8'h20;
        consumer_write_data[2]    = 8'h55;
        step(1);
        check("rs_wwait", 64'({mem_write_valid, grant_id}), 64'(4'b1010));
        reset = 1'b1;
        consumer_read_valid[0]   = 1'b1;
        consumer_read_address[0] = 8'h01;
        step(1);
        check("rs_mem", 64'({mem_read_valid, mem_read_address, mem_write_valid,
                             mem_write_address, mem_write_data}), 64'(0));
        check("rs_cons", 64'({consumer_read_ready, consumer_write_ready}), 64'(0));
        check("rs_rdata", 64'(consumer_read_data), 64'(0));
        check("rs_busy_grant", 64'({busy, grant_id}), 64'(0));
        reset = 1'b0;
        step(1);
        check("rs_first_grant", 64'(grant_id), 64'(0));
        check("rs_first_read",  64'({mem_read_valid, mem_read_address}), 64'(9'h101));

        check("inv_overlap",     64'(overlap_cnt), 64'(0));
        check("inv_multi_ready", 64'(multi_ready_cnt), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
